// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file datapath.
//   DEF_DATA_W   : default register/data width in bits
//   DEF_NUM_REGS : default number of architectural registers
//   CC_N/CC_Z/CC_P : {N,Z,P} condition-code encodings
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

endpackage

// File: rtl/nzp_gen.sv
// Combinational NZP classifier, shared by datapath blocks that need to
// derive condition codes from a data word.
//   data : DATA_W-bit value, interpreted as two's complement
//   nzp  : CC_N if negative, CC_Z if zero, CC_P otherwise
module nzp_gen
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] data,
    output logic [2:0]        nzp
);

    // Sign bit takes priority; zero is only possible with the sign bit clear.
    always_comb begin
        nzp = CC_P;
        if (data[DATA_W-1]) begin
            nzp = CC_N;
        end else if (data == '0) begin
            nzp = CC_Z;
        end
    end

endmodule

// File: rtl/reg_file_pipe.sv
// Pipelined register file with a busy-bit scoreboard and NZP condition codes.
//   clk, rst           : rising-edge clock, asynchronous active-high reset
//   rd_addr1/2         : read-port register selects
//   rd_data1/2         : combinational read data with write-through bypass
//   rd_busy1/2         : selected register has a pending reserved write
//   rsv_en, rsv_addr   : issue-stage reservation of a destination register
//   wr_en, wr_addr,
//   wr_data, wr_setcc  : writeback port, optionally updating cc
//   cc                 : registered {N,Z,P} condition codes
//   rsv_err            : one-cycle pulse after reserving an already-busy register
module reg_file_pipe
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_setcc,
    output logic [2:0]        cc,
    output logic              rsv_err
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wrSel;
    logic [NUM_REGS-1:0] rsvSel;
    logic [2:0]          wrNzp;
    logic                rsvConflict;

    nzp_gen #(
        .DATA_W(DATA_W)
    ) ccGen (
        .data(wr_data),
        .nzp (wrNzp)
    );

    // One-hot write/reserve selects. Out-of-range addresses (possible when
    // NUM_REGS is not a power of two) select nothing. The write select is
    // also suppressed during reset so the bypass cannot leak wr_data onto
    // the read ports while outputs must show reset values.
    always_comb begin
        wrSel  = '0;
        rsvSel = '0;
        if (wr_en && !rst && (int'(wr_addr) < NUM_REGS)) begin
            wrSel[wr_addr] = 1'b1;
        end
        if (rsv_en && (int'(rsv_addr) < NUM_REGS)) begin
            rsvSel[rsv_addr] = 1'b1;
        end
    end

    // A re-reservation is only an error if the register stays busy, i.e.
    // its outstanding write is not retiring in this same cycle.
    always_comb begin
        rsvConflict = 1'b0;
        if (rsvSel != '0) begin
            rsvConflict = busy[rsv_addr] && !wrSel[rsv_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrSel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Reservation is OR-ed in after the clear so a same-cycle reserve of the
    // register being written back leaves it busy for the next producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy    <= (busy & ~wrSel) | rsvSel;
            rsv_err <= rsvConflict;
        end
    end

    // Condition codes follow any setcc writeback, even to an ignored address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc <= CC_Z;
        end else if (wr_en && wr_setcc) begin
            cc <= wrNzp;
        end
    end

    // Read port 1: in-flight writeback data wins over stored contents, and a
    // register being written this cycle is no longer reported busy.
    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (int'(rd_addr1) < NUM_REGS) begin
            rd_data1 = wrSel[rd_addr1] ? wr_data : regs[rd_addr1];
            rd_busy1 = busy[rd_addr1] && !wrSel[rd_addr1];
        end
    end

    // Read port 2: identical behaviour, fully independent of port 1.
    always_comb begin
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (int'(rd_addr2) < NUM_REGS) begin
            rd_data2 = wrSel[rd_addr2] ? wr_data : regs[rd_addr2];
            rd_busy2 = busy[rd_addr2] && !wrSel[rd_addr2];
        end
    end

endmodule

// File: tb/tb_reg_file_pipe.sv
// Self-checking bench for reg_file_pipe: a default 16x8 instance compared
// every cycle against an array-based model, plus a 32-bit, 6-register
// instance exercising out-of-range addresses with literal expectations.
module tb_reg_file_pipe;

    logic        clk;
    logic        rst;
    logic [2:0]  rdAddr1, rdAddr2, rsvAddr, wrAddr;
    logic [15:0] rdData1, rdData2, wrData;
    logic        rdBusy1, rdBusy2, rsvEn, wrEn, wrSetcc, rsvErr;
    logic [2:0]  cc;

    logic [2:0]  bRdAddr1, bRdAddr2, bRsvAddr, bWrAddr;
    logic [31:0] bRdData1, bRdData2, bWrData;
    logic        bRdBusy1, bRdBusy2, bRsvEn, bWrEn, bWrSetcc, bRsvErr;
    logic [2:0]  bCc;

    int checks;
    int failures;

    logic [15:0] mReg [8];
    logic [7:0]  mBusy;
    logic [2:0]  mCc;
    logic        mErr;

    reg_file_pipe dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
        .rd_data1(rdData1), .rd_data2(rdData2),
        .rd_busy1(rdBusy1), .rd_busy2(rdBusy2),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_setcc(wrSetcc),
        .cc(cc), .rsv_err(rsvErr)
    );

    reg_file_pipe #(.DATA_W(32), .NUM_REGS(6)) dutWide (
        .clk(clk), .rst(rst),
        .rd_addr1(bRdAddr1), .rd_addr2(bRdAddr2),
        .rd_data1(bRdData1), .rd_data2(bRdData2),
        .rd_busy1(bRdBusy1), .rd_busy2(bRdBusy2),
        .rsv_en(bRsvEn), .rsv_addr(bRsvAddr),
        .wr_en(bWrEn), .wr_addr(bWrAddr), .wr_data(bWrData), .wr_setcc(bWrSetcc),
        .cc(bCc), .rsv_err(bRsvErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [2:0] nzpOf(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    // Reference model: architectural state after each edge, by the rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mReg[i] <= 16'd0;
            mBusy <= 8'd0;
            mCc   <= 3'b010;
            mErr  <= 1'b0;
        end else begin
            mErr <= rsvEn && mBusy[rsvAddr] && !(wrEn && wrAddr == rsvAddr);
            if (wrEn && wrSetcc) mCc <= nzpOf(wrData);
            if (wrEn) begin
                mReg[wrAddr]  <= wrData;
                mBusy[wrAddr] <= 1'b0;
            end
            if (rsvEn) mBusy[rsvAddr] <= 1'b1;
        end
    end

    function automatic logic [15:0] expRead(input logic [2:0] a);
        if (!rst && wrEn && wrAddr == a) return wrData;
        return mReg[a];
    endfunction

    function automatic logic expBusy(input logic [2:0] a);
        return mBusy[a] && !(!rst && wrEn && wrAddr == a);
    endfunction

    // Per-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        checkOutput("model_rd_data1", {16'd0, rdData1}, {16'd0, expRead(rdAddr1)});
        checkOutput("model_rd_data2", {16'd0, rdData2}, {16'd0, expRead(rdAddr2)});
        checkOutput("model_rd_busy1", {31'd0, rdBusy1}, {31'd0, expBusy(rdAddr1)});
        checkOutput("model_rd_busy2", {31'd0, rdBusy2}, {31'd0, expBusy(rdAddr2)});
        checkOutput("model_cc",       {29'd0, cc},      {29'd0, mCc});
        checkOutput("model_rsv_err",  {31'd0, rsvErr},  {31'd0, mErr});
    end

    task automatic applyStimulus(input logic rsv, input logic [2:0] rA,
                                 input logic wr, input logic [2:0] wA,
                                 input logic [15:0] wD, input logic setcc,
                                 input logic [2:0] a1, input logic [2:0] a2);
        @(posedge clk);
        #1;
        rsvEn = rsv; rsvAddr = rA;
        wrEn = wr; wrAddr = wA; wrData = wD; wrSetcc = setcc;
        rdAddr1 = a1; rdAddr2 = a2;
    endtask

    task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, a1, a2);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        rsvEn = 0; rsvAddr = 0; wrEn = 0; wrAddr = 0; wrData = 0; wrSetcc = 0;
        rdAddr1 = 0; rdAddr2 = 0;
        bRsvEn = 0; bRsvAddr = 0; bWrEn = 0; bWrAddr = 0; bWrData = 0; bWrSetcc = 0;
        bRdAddr1 = 0; bRdAddr2 = 0;

        // Writes held during reset must be lost and outputs stay at reset values.
        #2;
        wrEn = 1; wrAddr = 3'd0; wrData = 16'hBEEF; rdAddr1 = 3'd0;
        #1;
        checkOutput("reset_rd_data1", {16'd0, rdData1}, 32'h0);
        checkOutput("reset_cc", {29'd0, cc}, 32'h2);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wrEn = 0;

        // Write/read with condition codes.
        applyStimulus(0, 3'd0, 1, 3'd3, 16'h1234, 1, 3'd3, 3'd0);
        @(negedge clk);
        checkOutput("wr_bypass_r3", {16'd0, rdData1}, 32'h1234);
        idle(3'd3, 3'd0);
        @(negedge clk);
        checkOutput("read_r3", {16'd0, rdData1}, 32'h1234);
        checkOutput("cc_after_1234", {29'd0, cc}, 32'h1);
        applyStimulus(0, 3'd0, 1, 3'd5, 16'h8000, 1, 3'd5, 3'd3);
        idle(3'd5, 3'd3);
        @(negedge clk);
        checkOutput("read_r5", {16'd0, rdData1}, 32'h8000);
        checkOutput("cc_after_8000", {29'd0, cc}, 32'h4);

        // Both ports bypass the same in-flight write.
        applyStimulus(0, 3'd0, 1, 3'd2, 16'h00AA, 0, 3'd2, 3'd2);
        @(negedge clk);
        checkOutput("bypass_port1", {16'd0, rdData1}, 32'h00AA);
        checkOutput("bypass_port2", {16'd0, rdData2}, 32'h00AA);
        checkOutput("bypass_busy1", {31'd0, rdBusy1}, 32'h0);

        // Scoreboard: reserve, retire, then reserve-and-retire together.
        applyStimulus(1, 3'd4, 0, 3'd0, 16'h0, 0, 3'd4, 3'd2);
        idle(3'd4, 3'd2);
        @(negedge clk);
        checkOutput("r4_busy_after_rsv", {31'd0, rdBusy1}, 32'h1);
        applyStimulus(0, 3'd0, 1, 3'd4, 16'h0044, 0, 3'd4, 3'd4);
        @(negedge clk);
        checkOutput("r4_busy_during_wb", {31'd0, rdBusy2}, 32'h0);
        idle(3'd4, 3'd2);
        @(negedge clk);
        checkOutput("r4_busy_cleared", {31'd0, rdBusy1}, 32'h0);
        applyStimulus(1, 3'd4, 0, 3'd0, 16'h0, 0, 3'd4, 3'd2);
        applyStimulus(1, 3'd4, 1, 3'd4, 16'h0066, 0, 3'd4, 3'd2);
        idle(3'd4, 3'd2);
        @(negedge clk);
        checkOutput("r4_busy_rsv_wr", {31'd0, rdBusy1}, 32'h1);
        checkOutput("r4_rsv_wr_no_err", {31'd0, rsvErr}, 32'h0);
        checkOutput("r4_data_0066", {16'd0, rdData1}, 32'h0066);

        // Double reservation raises a one-cycle error pulse.
        applyStimulus(1, 3'd1, 0, 3'd0, 16'h0, 0, 3'd1, 3'd4);
        applyStimulus(1, 3'd1, 0, 3'd0, 16'h0, 0, 3'd1, 3'd4);
        @(negedge clk);
        checkOutput("r1_no_err_yet", {31'd0, rsvErr}, 32'h0);
        idle(3'd1, 3'd4);
        @(negedge clk);
        checkOutput("r1_err_pulse", {31'd0, rsvErr}, 32'h1);
        checkOutput("r1_busy", {31'd0, rdBusy1}, 32'h1);
        idle(3'd1, 3'd4);
        @(negedge clk);
        checkOutput("r1_err_gone", {31'd0, rsvErr}, 32'h0);
        checkOutput("r1_still_busy", {31'd0, rdBusy1}, 32'h1);
        applyStimulus(0, 3'd0, 1, 3'd1, 16'h0000, 1, 3'd1, 3'd4);
        idle(3'd1, 3'd4);
        @(negedge clk);
        checkOutput("cc_zero", {29'd0, cc}, 32'h2);

        // Fill every register, reading back on both ports.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 3'd0, 1, 3'(i), 16'(i * 16'h1111), 1, 3'(i), 3'((i + 7) % 8));
        end
        idle(3'd7, 3'd6);
        @(negedge clk);
        checkOutput("fill_r7", {16'd0, rdData1}, 32'h7777);
        checkOutput("fill_r6", {16'd0, rdData2}, 32'h6666);
        checkOutput("fill_cc", {29'd0, cc}, 32'h1);

        // Asynchronous reset mid-cycle with a reservation and a write pending.
        applyStimulus(1, 3'd6, 0, 3'd0, 16'h0, 0, 3'd6, 3'd3);
        applyStimulus(0, 3'd0, 1, 3'd3, 16'hFFFF, 1, 3'd6, 3'd3);
        #1;
        checkOutput("pre_reset_busy6", {31'd0, rdBusy1}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rd_data1", {16'd0, rdData1}, 32'h0);
        checkOutput("async_rd_busy1", {31'd0, rdBusy1}, 32'h0);
        checkOutput("async_rd_data2", {16'd0, rdData2}, 32'h0);
        checkOutput("async_cc", {29'd0, cc}, 32'h2);
        checkOutput("async_rsv_err", {31'd0, rsvErr}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wrEn = 0; wrSetcc = 0;
        @(negedge clk);
        checkOutput("write_lost_in_reset", {16'd0, rdData2}, 32'h0);
        checkOutput("cc_after_reset", {29'd0, cc}, 32'h2);

        // Wide instance with six registers: addresses 6 and 7 are absent.
        @(posedge clk);
        #1;
        bWrEn = 1; bWrAddr = 3'd5; bWrData = 32'h0000_0001; bWrSetcc = 1;
        bRdAddr1 = 3'd5; bRdAddr2 = 3'd6;
        @(posedge clk);
        #1;
        bWrAddr = 3'd7; bWrData = 32'hDEAD_BEEF; bWrSetcc = 0;
        bRsvEn = 1; bRsvAddr = 3'd7;
        bRdAddr1 = 3'd7; bRdAddr2 = 3'd5;
        @(negedge clk);
        checkOutput("wide_cc_pos", {29'd0, bCc}, 32'h1);
        checkOutput("wide_no_bypass_a7", bRdData1, 32'h0);
        checkOutput("wide_read_r5", bRdData2, 32'h0000_0001);
        @(posedge clk);
        #1;
        bRsvEn = 0;
        bWrAddr = 3'd7; bWrData = 32'h0; bWrSetcc = 1;
        bRdAddr1 = 3'd7; bRdAddr2 = 3'd6;
        @(posedge clk);
        #1;
        bWrEn = 0; bWrSetcc = 0;
        @(negedge clk);
        checkOutput("wide_read_a7", bRdData1, 32'h0);
        checkOutput("wide_read_a6", bRdData2, 32'h0);
        checkOutput("wide_busy_a7", {31'd0, bRdBusy1}, 32'h0);
        checkOutput("wide_rsv_err", {31'd0, bRsvErr}, 32'h0);
        checkOutput("wide_cc_zero", {29'd0, bCc}, 32'h2);
        bRdAddr1 = 3'd5;
        #1;
        checkOutput("wide_r5_kept", bRdData1, 32'h0000_0001);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
